// File: rtl/rst_sequencer_pkg.sv
// rtl/rst_sequencer_pkg.sv - shared state encodings, defaults and helpers for the reset sequencer
//
// Purpose : constants shared by the reset sequencer and its bench.
// Contents: RS_* state encodings (values visible on STATE_O), default
//           parameter values, LOSS_CNT width and a saturating increment.
package rst_sequencer_pkg;

    localparam logic [1:0] RS_HOLD = 2'd0;
    localparam logic [1:0] RS_WAIT = 2'd1;
    localparam logic [1:0] RS_REL  = 2'd2;
    localparam logic [1:0] RS_RUN  = 2'd3;

    localparam int DEF_NUM_STAGES    = 4;
    localparam int DEF_STABLE_CYCLES = 256;
    localparam int DEF_STAGE_GAP     = 16;
    localparam int DEF_HOLD_MIN      = 8;
    localparam int DEF_CNT_W         = 16;

    localparam int LOSS_W = 8;

    function automatic logic [LOSS_W-1:0] sat_inc(input logic [LOSS_W-1:0] v);
        return (v == {LOSS_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rst_sequencer_sync2.sv
// rtl/rst_sequencer_sync2.sv - two-flop synchronizer with synchronous reset
//
// Purpose : bring an asynchronous level into the clk_i domain.
// Ports   : clk_i  destination clock
//           rst_i  synchronous active-high reset, clears both flops
//           d_i    asynchronous input
//           q_o    synchronized output, 2 edges of latency
module rst_sequencer_sync2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/rst_sequencer.sv
// rtl/rst_sequencer.sv - staged reset release sequencer driven by MMCM lock
//
// Purpose : hold all pipeline stages in reset until the synchronized lock has
//           been stable, then release stage 0..NUM_STAGES-1 in order with a
//           fixed gap; lock loss or a soft-reset request re-asserts everything.
// Ports   : CLK       user clock
//           RST       synchronous active-high reset
//           LOCKED_I  MMCM lock, asynchronous to CLK
//           SRST_REQ  soft-reset request pulse (honoured in RELEASE/RUN only)
//           RST_O     per-stage active-high reset, bit k = stage k
//           READY     all stages released
//           LOSS_CNT  saturating lock-loss event count
//           STATE_O   0=HOLD 1=WAIT_LOCK 2=RELEASE 3=RUN
module rst_sequencer
    import rst_sequencer_pkg::*;
#(
    parameter int NUM_STAGES    = DEF_NUM_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int STAGE_GAP     = DEF_STAGE_GAP,
    parameter int HOLD_MIN      = DEF_HOLD_MIN,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  LOCKED_I,
    input  logic                  SRST_REQ,
    output logic [NUM_STAGES-1:0] RST_O,
    output logic                  READY,
    output logic [LOSS_W-1:0]     LOSS_CNT,
    output logic [1:0]            STATE_O
);

    localparam int STG_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_MIN - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(STAGE_GAP - 1);
    localparam logic [STG_W-1:0] LAST_STG    = STG_W'(NUM_STAGES - 1);

    logic                  lock_s;

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q,   cnt_d;
    logic [STG_W-1:0]      stg_q,   stg_d;
    logic [NUM_STAGES-1:0] rst_q,   rst_d;
    logic                  ready_q, ready_d;
    logic [LOSS_W-1:0]     loss_q,  loss_d;
    logic [STG_W-1:0]      stg_nxt;

    rst_sequencer_sync2 u_lock_sync (
        .clk_i (CLK),
        .rst_i (RST),
        .d_i   (LOCKED_I),
        .q_o   (lock_s)
    );

    assign stg_nxt = stg_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stg_d   = stg_q;
        rst_d   = rst_q;
        ready_d = ready_q;
        loss_d  = loss_q;

        case (state_q)
            RS_HOLD: begin
                rst_d   = '1;
                ready_d = 1'b0;
                if (cnt_q == HOLD_LAST) begin
                    state_d = RS_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            RS_WAIT: begin
                // Any low sample restarts the stability window; not a loss event.
                if (!lock_s) begin
                    cnt_d = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    cnt_d    = '0;
                    stg_d    = '0;
                    rst_d[0] = 1'b0;
                    if (NUM_STAGES == 1) begin
                        state_d = RS_RUN;
                        ready_d = 1'b1;
                    end else begin
                        state_d = RS_REL;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                if (!lock_s || SRST_REQ) begin
                    state_d = RS_HOLD;
                    cnt_d   = '0;
                    stg_d   = '0;
                    rst_d   = '1;
                    ready_d = 1'b0;
                    if (!lock_s) begin
                        loss_d = sat_inc(loss_q);
                    end
                end else if (state_q == RS_REL) begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_d = '0;
                        stg_d = stg_nxt;
                        // Released stages are always a contiguous low run, so
                        // shifting in a zero releases exactly the next stage.
                        rst_d = rst_q << 1;
                        if (stg_nxt == LAST_STG) begin
                            state_d = RS_RUN;
                            ready_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    rst_d   = '0;
                    ready_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= RS_HOLD;
            cnt_q   <= '0;
            stg_q   <= '0;
            rst_q   <= '1;
            ready_q <= 1'b0;
            loss_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stg_q   <= stg_d;
            rst_q   <= rst_d;
            ready_q <= ready_d;
            loss_q  <= loss_d;
        end
    end

    assign RST_O    = rst_q;
    assign READY    = ready_q;
    assign LOSS_CNT = loss_q;
    assign STATE_O  = state_q;

endmodule
